// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the CPU memory subsystem. The control unit, the RAM
// and the memory port arbiter all use these.
//   - arb_state_t : arbiter sequencing states (IDLE/ACCESS/WAIT/DONE)
//   - REQ_CPU / REQ_LDR : requester IDs used for grant and owner
//   - ADDR_W_DEF / DATA_W_DEF : default RAM address and data widths
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way combinational arbiter for the memory port.
// Tie-break: round-robin against last_owner by default. When the macro
// ARB_FIXED_PRIO_EN is defined, the CPU always wins a tie.
// Ports:
//   req_cpu    in  CPU request
//   req_ldr    in  loader request
//   last_owner in  previous grantee (REQ_CPU / REQ_LDR)
//   grant      out selected requester; only meaningful when a request is present
// -----------------------------------------------------------------------------
module rr_arbiter2
   import cpu_mem_pkg::*;
(
   input  logic req_cpu,
   input  logic req_ldr,
   input  logic last_owner,
   output logic grant
);

   always_comb begin
      grant = last_owner;
      if (req_cpu && req_ldr) begin
`ifdef ARB_FIXED_PRIO_EN
         grant = REQ_CPU;
`else
         grant = ~last_owner;
`endif
      end else if (req_cpu) begin
         grant = REQ_CPU;
      end else if (req_ldr) begin
         grant = REQ_LDR;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single synchronous RAM between the CPU memory path (port 0) and
// the program/data loader (port 1). It owns every RAM strobe and hides the RAM
// read latency behind a req/done handshake.
// Optional feature: define ARB_FIXED_PRIO_EN for fixed CPU priority on ties
// (the default is round-robin). The switch is inside rr_arbiter2.
// Ports:
//   Clock, Reset_n          clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata   CPU request (level, held until cpu_done)
//   cpu_rdata, cpu_done     CPU read data (held), one-cycle completion
//   ldr_req/we/addr/wdata   loader request
//   ldr_rdata, ldr_done     loader read data (held), one-cycle completion
//   mem_en/we/addr/wdata    RAM strobes; mem_en is one cycle per transaction
//   mem_rdata               RAM read data
//   owner                   current or last grantee (0 = CPU, 1 = loader)
//   busy                    high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 1
)(
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner,
   output logic              busy
);

   // WAIT counts down from WAIT_CYCLES-1; data is captured when it hits 0.
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

   arb_state_t state_q, state_d;
   logic [3:0] cnt_q;
   logic       we_q;
   logic       owner_q;
   logic       any_req;
   logic       grant;

   assign any_req = cpu_req | ldr_req;

   rr_arbiter2 u_arb (
      .req_cpu    (cpu_req),
      .req_ldr    (ldr_req),
      .last_owner (owner_q),
      .grant      (grant)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  state_d = we_q ? DONE : WAIT;
         WAIT:    if (cnt_q == 4'd0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         we_q      <= 1'b0;
         owner_q   <= REQ_LDR;   // so the CPU wins the first tie
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rdata <= '0;
         ldr_rdata <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            // Grant edge: the requester's inputs are not looked at again.
            IDLE: begin
               if (any_req) begin
                  owner_q   <= grant;
                  we_q      <= (grant == REQ_LDR) ? ldr_we    : cpu_we;
                  mem_addr  <= (grant == REQ_LDR) ? ldr_addr  : cpu_addr;
                  mem_wdata <= (grant == REQ_LDR) ? ldr_wdata : cpu_wdata;
               end
            end
            ACCESS: cnt_q <= WAIT_INIT;
            // Only the owner's rdata register is ever written.
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  if (owner_q == REQ_LDR) ldr_rdata <= mem_rdata;
                  else                    cpu_rdata <= mem_rdata;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Strobes decode straight from state, so an asynchronous reset drops them
   // immediately.
   assign mem_en   = (state_q == ACCESS);
   assign mem_we   = mem_en & we_q;
   assign busy     = (state_q != IDLE);
   assign cpu_done = (state_q == DONE) && (owner_q == REQ_CPU);
   assign ldr_done = (state_q == DONE) && (owner_q == REQ_LDR);
   assign owner    = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Randomized requesters against a transaction-level reference model of the
// arbiter, plus a directed mid-transaction reset.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW     = 9;
   localparam int DW     = 32;
   localparam int W      = 3;
   localparam int N_RAND = 2500;
`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          Clock = 1'b0;
   logic          Reset_n;
   logic          cpu_req, cpu_we, ldr_req, ldr_we;
   logic [AW-1:0] cpu_addr, ldr_addr, mem_addr;
   logic [DW-1:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata;
   logic          cpu_done, ldr_done, mem_en, mem_we, owner, busy;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 Clock = ~Clock;

   // Requester drive state, index 0 = CPU, 1 = loader
   logic          rq  [2];
   logic          rwe [2];
   logic [AW-1:0] ra  [2];
   logic [DW-1:0] rwd [2];

   assign cpu_req   = rq[0];
   assign cpu_we    = rwe[0];
   assign cpu_addr  = ra[0];
   assign cpu_wdata = rwd[0];
   assign ldr_req   = rq[1];
   assign ldr_we    = rwe[1];
   assign ldr_addr  = ra[1];
   assign ldr_wdata = rwd[1];

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_done  (cpu_done),
      .ldr_req   (ldr_req),
      .ldr_we    (ldr_we),
      .ldr_addr  (ldr_addr),
      .ldr_wdata (ldr_wdata),
      .ldr_rdata (ldr_rdata),
      .ldr_done  (ldr_done),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .owner     (owner),
      .busy      (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 7) == 0) return AW'($urandom);
      return AW'($urandom_range(0, 15));
   endfunction

   task automatic new_fields(input int r);
      rwe[r] = 1'($urandom_range(0, 1));
      ra[r]  = rnd_addr();
      rwd[r] = $urandom;
   endtask

   // RAM as seen on the pins (ram) and RAM as the model believes it is (mram)
   logic [DW-1:0] ram  [512];
   logic [DW-1:0] mram [512];

   // Reference model: one transaction in flight at most
   bit            m_busy, m_owner, m_we, m_g;
   int            m_start, m_lat, free_at, n_tx;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rd [2];
   bit            granted [2];
   bit            served  [2];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int            c, k, rd_due;
      bit            act, dn, done_loop;
      logic [AW-1:0] rd_addr;

      for (int i = 0; i < 512; i++) begin
         ram[i]  = $urandom;
         mram[i] = ram[i];
      end
      for (int r = 0; r < 2; r++) begin
         rq[r] = 1'b0; rwe[r] = 1'b0; ra[r] = '0; rwd[r] = '0;
         m_rd[r] = '0; granted[r] = 1'b0; served[r] = 1'b0;
      end
      Reset_n   = 1'b0;
      mem_rdata = '0;
      m_busy = 1'b0; m_owner = 1'b1; m_we = 1'b0; m_g = 1'b0;
      m_start = 0; m_lat = 0; free_at = 0; n_tx = 0;
      m_addr = '0; m_wdata = '0;
      rd_due = -1; rd_addr = '0;
      c = 0; done_loop = 1'b0;

      while (!done_loop) begin
         @(negedge Clock);
         cyc = c;

         // Compare this cycle's outputs against the model
         k   = c - m_start;
         act = m_busy && (c > m_start);
         dn  = act && (k == m_lat);
         chk("busy",   32'(busy),   32'(act));
         chk("mem_en", 32'(mem_en), 32'(act && k == 1));
         chk("mem_we", 32'(mem_we), 32'(act && k == 1 && m_we));
         chk("owner",  32'(owner),  32'(m_owner));
         if (act && k == 1) begin
            chk("mem_addr",  32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", mem_wdata,     m_wdata);
            if (m_we) mram[m_addr] = m_wdata;
         end
         if (dn && !m_we) m_rd[m_g] = mram[m_addr];
         chk("cpu_done",  32'(cpu_done), 32'(dn && m_g == 1'b0));
         chk("ldr_done",  32'(ldr_done), 32'(dn && m_g == 1'b1));
         chk("cpu_rdata", cpu_rdata, m_rd[0]);
         chk("ldr_rdata", ldr_rdata, m_rd[1]);
         served[0] = 1'b0;
         served[1] = 1'b0;
         if (dn) begin
            served[m_g]  = 1'b1;
            granted[m_g] = 1'b0;
            m_busy  = 1'b0;
            free_at = c + 1;
            n_tx++;
         end
         if (c == 0) begin
            chk("rst_mem_addr",  32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", mem_wdata,     32'd0);
            Reset_n = 1'b1;
         end

         // RAM environment: read data is valid only in cycle ACCESS+W
         if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else begin
               rd_due  = c + W;
               rd_addr = mem_addr;
            end
         end
         mem_rdata = (c == rd_due) ? ram[rd_addr] : $urandom;

         // Requester behaviour for the next edge
         for (int r = 0; r < 2; r++) begin
            if (c == 0) begin
               rq[r] = 1'b1;
               new_fields(r);
            end else if (served[r]) begin
               if (c < N_RAND && (n_tx <= 4 || $urandom_range(0, 2) == 0)) begin
                  rq[r] = 1'b1;
                  new_fields(r);
               end else begin
                  rq[r] = 1'b0;
               end
            end else if (granted[r]) begin
               new_fields(r);
            end else if (!rq[r]) begin
               if (c < N_RAND && $urandom_range(0, 3) == 0) begin
                  rq[r] = 1'b1;
                  new_fields(r);
               end
            end
         end

         // Arbitration decision for a free cycle
         if (!m_busy && c >= free_at && (rq[0] || rq[1])) begin
            if (rq[0] && rq[1]) m_g = FIXED ? 1'b0 : ~m_owner;
            else                m_g = rq[1];
            m_owner = m_g;
            m_busy  = 1'b1;
            m_start = c;
            m_we    = rwe[m_g];
            m_addr  = ra[m_g];
            m_wdata = rwd[m_g];
            m_lat   = m_we ? 2 : 2 + W;
            granted[m_g] = 1'b1;
         end

         if (c >= N_RAND && !m_busy && !rq[0] && !rq[1]) begin
            done_loop = 1'b1;
         end else if (c >= N_RAND + 500) begin
            chk("drain_idle", 32'(m_busy || rq[0] || rq[1]), 32'd0);
            done_loop = 1'b1;
         end
         c++;
      end

      // Directed: reset in the second WAIT cycle of a CPU read
      @(negedge Clock);
      rq[0] = 1'b1; rwe[0] = 1'b0; ra[0] = 9'h005; rwd[0] = '0;
      mem_rdata = 32'hDEADBEEF;
      @(negedge Clock);
      chk("abort_access_en", 32'(mem_en), 32'd1);
      rq[0] = 1'b0;
      @(negedge Clock);
      chk("abort_wait1_busy", 32'(busy),   32'd1);
      chk("abort_wait1_en",   32'(mem_en), 32'd0);
      @(negedge Clock);
      chk("abort_wait2_busy", 32'(busy), 32'd1);
      #1 Reset_n = 1'b0;
      #1;
      chk("abort_mem_en",    32'(mem_en),   32'd0);
      chk("abort_busy",      32'(busy),     32'd0);
      chk("abort_cpu_done",  32'(cpu_done), 32'd0);
      chk("abort_ldr_done",  32'(ldr_done), 32'd0);
      chk("abort_cpu_rdata", cpu_rdata,     32'd0);
      chk("abort_ldr_rdata", ldr_rdata,     32'd0);
      chk("abort_owner",     32'(owner),    32'd1);
      chk("abort_mem_addr",  32'(mem_addr), 32'd0);
      @(negedge Clock);
      Reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         chk("post_abort_cpu_done", 32'(cpu_done), 32'd0);
         chk("post_abort_ldr_done", 32'(ldr_done), 32'd0);
         chk("post_abort_mem_en",   32'(mem_en),   32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
